mdu_pipelined: RTL and testbench



---
 rtl/mdu_pipelined.sv | 174 +++++++++++++++++
 tb/tb_mdu_pipelined.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_pipelined.sv
// mdu_pipelined: multi-cycle multiply/divide unit with architectural HI/LO state.
//
// A mult/div-class start accepted while idle computes the full 2*WIDTH result at
// once and parks it in a shadow register. busy stays high for MULT_CYCLES or
// DIV_CYCLES cycles, and then the shadow is committed to HI/LO. MTHI/MTLO write
// HI/LO on the accept edge. Any start seen while busy is dropped.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB (op 110/111), which
// accumulate a signed product into {hi, lo}. When it is undefined these ops are no-ops.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   start     operation request, sampled at rising clk
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//             110 MADD, 111 MSUB
//   operand1  rs value
//   operand2  rt value
//   busy      multi-cycle operation in flight
//   hi, lo    committed HI/LO registers
module mdu_pipelined #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned W2        = 2 * WIDTH;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;
`endif

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state;
    logic [CntW-1:0] count;
    logic [W2-1:0]   shadow;

    // Products: sign-extended operands multiplied modulo 2^W2 give the signed product.
    logic [W2-1:0] prod_s;
    logic [W2-1:0] prod_u;

    assign prod_u = {{WIDTH{1'b0}}, operand1} * {{WIDTH{1'b0}}, operand2};
    assign prod_s = {{WIDTH{operand1[WIDTH-1]}}, operand1}
                  * {{WIDTH{operand2[WIDTH-1]}}, operand2};

    // One shared unsigned divider. Signed division runs on magnitudes and fixes
    // signs afterwards. MIN / -1 then falls out naturally as lo=MIN, hi=0.
    logic             div_signed;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    always_comb begin
        div_signed = (op == OpDiv);
        neg1       = div_signed & operand1[WIDTH-1];
        neg2       = div_signed & operand2[WIDTH-1];
        num        = neg1 ? -operand1 : operand1;
        den        = neg2 ? -operand2 : operand2;
        // Guard against a zero divisor. The result is discarded in that case anyway.
        if (den == '0) begin
            den = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        div_q = num / den;
        div_r = num % den;
        quot  = (neg1 ^ neg2) ? -div_q : div_q;
        rem   = neg1 ? -div_r : div_r;
    end

    // Full result for the op being offered. It defaults to the current {hi, lo}, so a
    // divide by zero commits an unchanged value.
    logic [W2-1:0] result;
    logic          is_long;
    logic          is_div;

    always_comb begin
        result  = {hi, lo};
        is_long = 1'b0;
        is_div  = 1'b0;
        case (op)
            OpMult: begin
                result  = prod_s;
                is_long = 1'b1;
            end
            OpMultu: begin
                result  = prod_u;
                is_long = 1'b1;
            end
            OpDiv, OpDivu: begin
                if (operand2 != '0) begin
                    result = {rem, quot};
                end
                is_long = 1'b1;
                is_div  = 1'b1;
            end
`ifdef MDU_MADD_EN
            OpMadd: begin
                result  = {hi, lo} + prod_s;
                is_long = 1'b1;
            end
            OpMsub: begin
                result  = {hi, lo} - prod_s;
                is_long = 1'b1;
            end
`endif
            default: result = {hi, lo};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            count  <= '0;
            shadow <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        if (is_long) begin
                            shadow <= result;
                            count  <= is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            busy   <= 1'b1;
                            state  <= StBusy;
                        end else if (op == OpMthi) begin
                            hi <= operand1;
                        end else if (op == OpMtlo) begin
                            lo <= operand1;
                        end
                    end
                end
                StBusy: begin
                    // Any start arriving here is dropped on purpose.
                    if (count == CntW'(1)) begin
                        {hi, lo} <= shadow;
                        count    <= '0;
                        busy     <= 1'b0;
                        state    <= StIdle;
                    end else begin
                        count <= count - CntW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_pipelined.sv
// Self-checking bench for mdu_pipelined. A behavioural model computes HI/LO and
// busy from the arithmetic rules. A compare process checks them every cycle, and
// directed cases pin literal values.
module tb_mdu_pipelined;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mdu_pipelined #(
        .WIDTH      (W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand1(operand1),
        .operand2(operand2),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: the pending result is committed after the latency has elapsed.
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;
    longint      sa, sb, sq, sr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (start) begin
            sa = longint'($signed(operand1));
            sb = longint'($signed(operand2));
            case (op)
                3'd0: begin m_pend = sa * sb; m_left = MC; end
                3'd1: begin m_pend = {32'd0, operand1} * {32'd0, operand2}; m_left = MC; end
                3'd2: begin
                    if (operand2 == '0) m_pend = {m_hi, m_lo};
                    else begin
                        sq = sa / sb;
                        sr = sa % sb;
                        m_pend = {sr[31:0], sq[31:0]};
                    end
                    m_left = DC;
                end
                3'd3: begin
                    if (operand2 == '0) m_pend = {m_hi, m_lo};
                    else m_pend = {operand1 % operand2, operand1 / operand2};
                    m_left = DC;
                end
                3'd4: m_hi = operand1;
                3'd5: m_lo = operand1;
`ifdef MDU_MADD_EN
                3'd6: begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_left = MC; end
                3'd7: begin m_pend = {m_hi, m_lo} - 64'(sa * sb); m_left = MC; end
`endif
                default: ;
            endcase
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("busy_vs_model", 64'(busy), 64'(m_left > 0));
            check("hi_vs_model", 64'(hi), 64'(m_hi));
            check("lo_vs_model", 64'(lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts busy cycles seen at negedges after the accept edge. It returns on the
    // first idle negedge.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
        end
        if (cycles >= 100) check("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    int c;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        operand1 = '0;
        operand2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        cmp_en = 1'b1;

        // MULT -3 * 5
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        wait_idle(c);
        check("mult_cycles", 64'(c), 64'(5));
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFF1);

        // MULTU, then DIV issued on the first idle cycle
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(c);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFFFFFE);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(c);
        check("div_b2b_cycles", 64'(c), 64'(10));
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_hi", 64'(hi), 64'hFFFFFFFF);

        // Signed overflow
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(c);
        check("divovf_lo", 64'(lo), 64'h80000000);
        check("divovf_hi", 64'(hi), 64'h0);

        // MTLO 0, MTHI, then DIVU by zero
        issue(3'd5, 32'h0, 32'h0);
        @(negedge clk);
        issue(3'd4, 32'h12345678, 32'h0);
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_busy", 64'(busy), 64'(0));
        issue(3'd3, 32'd9, 32'd0);
        wait_idle(c);
        check("divu0_cycles", 64'(c), 64'(10));
        check("divu0_hi", 64'(hi), 64'h12345678);
        check("divu0_lo", 64'(lo), 64'h0);

        // MTLO issued while busy is ignored
        issue(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        issue(3'd5, 32'hAAAA5555, 32'h0);
        wait_idle(c);
        check("ignored_mtlo_lo", 64'(lo), 64'd42);
        check("ignored_mtlo_hi", 64'(hi), 64'd0);

        // Reset pulsed mid-division
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        #1 reset = 1'b0;
        @(negedge clk);

        // MADD / MSUB
        issue(3'd4, 32'h0, 32'h0);
        @(negedge clk);
        issue(3'd5, 32'd10, 32'h0);
        @(negedge clk);
        issue(3'd6, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        wait_idle(c);
        check("madd_cycles", 64'(c), 64'(5));
        check("madd_lo", 64'(lo), 64'd22);
        issue(3'd7, 32'hFFFFFFFF, 32'd1);
        wait_idle(c);
        check("msub_lo", 64'(lo), 64'd23);
        check("msub_hi", 64'(hi), 64'd0);
`else
        @(negedge clk);
        check("madd_off_busy", 64'(busy), 64'(0));
        check("madd_off_lo", 64'(lo), 64'd10);
`endif

        // Random traffic, including starts while busy
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            op       = 3'($urandom_range(0, 7));
            operand1 = pick();
            operand2 = pick();
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle(c);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
